// File: rtl/montgomery_mult.sv
// -----------------------------------------------------------------------------
// montgomery_mult
//
// Radix-2 bit-serial Montgomery multiplier:
//   result = in_a * in_b * 2^-N mod in_m
// One iteration per clock with a single (N+2)-bit adder. Responds to a
// start/done handshake and holds its result until the next accepted request.
//
// Build option:
//   MONT_FINAL_SUBTRACT_EN  defined   -> final conditional subtraction (SUB
//                                        state), result < in_m, latency N+2.
//                           undefined -> no SUB state, result < 2*in_m and
//                                        congruent, latency N+1.
//
// Ports:
//   clk     in   1  system clock, rising edge
//   resetn  in   1  asynchronous active-low reset
//   start   in   1  request strobe, sampled only in IDLE or DONE
//   in_a    in   N  multiplier operand, captured on the start edge
//   in_b    in   N  multiplicand operand, captured on the start edge
//   in_m    in   N  odd modulus, captured on the start edge
//   result  out  N  Montgomery product, valid from done until next start
//   done    out  1  one-cycle completion pulse
//   busy    out  1  high from the accepted start until done rises
// -----------------------------------------------------------------------------
module montgomery_mult #(
  parameter int N = 512
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy
);

  localparam int            IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOOP,
    SUB,
    DONE
  } state_t;

  state_t        state;
  logic [N-1:0]  ra;
  logic [N+1:0]  rb;
  logic [N+1:0]  rm;
  logic [N+1:0]  rbm;
  logic [N+1:0]  c;
  logic [IW-1:0] i;

  logic          a_i;
  logic          q;
  logic [N+1:0]  add;
  logic [N+1:0]  sum;
  logic [N+1:0]  c_next;

  // One Montgomery iteration: q is chosen so that c + a_i*b + q*m is even,
  // which makes the following right shift an exact division by two.
  // NOTE: every signal gets a value on every path through always_comb,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    a_i = ra[i];
    q   = c[0] ^ (a_i & rb[0]);
    case ({a_i, q})
      2'b00:   add = '0;
      2'b10:   add = rb;
      2'b01:   add = rm;
      default: add = rbm;
    endcase
    sum    = c + add;
    c_next = sum >> 1;
  end

`ifdef MONT_FINAL_SUBTRACT_EN
  logic         c_ge;
  logic [N+1:0] c_sub;

  assign c_ge  = (c >= rm);
  assign c_sub = c - rm;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      rm     <= '0;
      rbm    <= '0;
      c      <= '0;
      i      <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new request exactly like IDLE, so back-to-back
        // operations run with no gap.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= in_a;
            rb    <= {2'b00, in_b};
            rm    <= {2'b00, in_m};
            c     <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end else begin
            state <= IDLE;
          end
        end

        LOAD: begin
          rbm   <= rb + rm;
          i     <= '0;
          state <= LOOP;
        end

        LOOP: begin
          c <= c_next;
          i <= i + 1'b1;
          if (i == LAST) begin
`ifdef MONT_FINAL_SUBTRACT_EN
            state  <= SUB;
`else
            result <= c_next[N-1:0];
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
`endif
          end
        end

`ifdef MONT_FINAL_SUBTRACT_EN
        SUB: begin
          if (c_ge) begin
            c      <= c_sub;
            result <= c_sub[N-1:0];
          end else begin
            result <= c[N-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mult.sv
// -----------------------------------------------------------------------------
// tb_montgomery_mult
//
// Self-checking bench for montgomery_mult at N=8 and N=512. A behavioural
// model computes a*b*2^-N mod m by plain modular arithmetic (product mod m,
// then N modular halvings) and tracks the handshake as "cycles since the
// accepted start edge". One compare process per instance checks done, busy
// and result every cycle on the falling edge. Directed N=8 vectors carry
// hand-computed literal results; N=512 uses random vectors that satisfy the
// operand preconditions. Honours MONT_FINAL_SUBTRACT_EN like the design.
// -----------------------------------------------------------------------------
module tb_montgomery_mult;

`ifdef MONT_FINAL_SUBTRACT_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 1;
`endif
  localparam int LAT8   = 8 + EXTRA;
  localparam int LAT512 = 512 + EXTRA;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  logic         start8 = 1'b0;
  logic [7:0]   a8 = '0, b8 = '0, m8 = '0;
  logic [7:0]   result8;
  logic         done8, busy8;

  logic         start5 = 1'b0;
  logic [511:0] a5 = '0, b5 = '0, m5 = '0;
  logic [511:0] result5;
  logic         done5, busy5;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  montgomery_mult #(.N(8)) dut8 (
    .clk    (clk),
    .resetn (resetn),
    .start  (start8),
    .in_a   (a8),
    .in_b   (b8),
    .in_m   (m8),
    .result (result8),
    .done   (done8),
    .busy   (busy8)
  );

  montgomery_mult #(.N(512)) dut512 (
    .clk    (clk),
    .resetn (resetn),
    .start  (start5),
    .in_a   (a5),
    .in_b   (b5),
    .in_m   (m5),
    .result (result5),
    .done   (done5),
    .busy   (busy5)
  );

  task automatic check(input string name, input logic [511:0] actual,
                       input logic [511:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Golden value: (a*b mod m) then divide by 2 modulo m, n times.
  function automatic logic [511:0] mont_ref(input logic [511:0] a, input logic [511:0] b,
                                            input logic [511:0] m, input int n);
    logic [1023:0] p;
    logic [512:0]  x;
    p = {512'b0, a} * {512'b0, b};
    p = p % {512'b0, m};
    x = p[512:0];
    for (int k = 0; k < n; k++) begin
      if (x[0]) x = (x + {1'b0, m}) >> 1;
      else      x = x >> 1;
    end
    return x[511:0];
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  // ---------------------------------------------------------------- model
  bit           act8 = 1'b0, act5 = 1'b0;
  int           k8 = 0, k5 = 0;
  logic [511:0] exp8 = '0, em8 = '0, exp5 = '0, em5 = '0;
  logic [7:0]   held8 = '0;
  logic [511:0] held5 = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      act8 <= 1'b0;
      k8   <= 0;
    end else if ((!act8 || k8 == LAT8) && start8) begin
      act8 <= 1'b1;
      k8   <= 0;
      exp8 <= mont_ref({504'b0, a8}, {504'b0, b8}, {504'b0, m8}, 8);
      em8  <= {504'b0, m8};
    end else if (act8) begin
      if (k8 == LAT8) act8 <= 1'b0;
      else            k8   <= k8 + 1;
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      act5 <= 1'b0;
      k5   <= 0;
    end else if ((!act5 || k5 == LAT512) && start5) begin
      act5 <= 1'b1;
      k5   <= 0;
      exp5 <= mont_ref(a5, b5, m5, 512);
      em5  <= m5;
    end else if (act5) begin
      if (k5 == LAT512) act5 <= 1'b0;
      else              k5   <= k5 + 1;
    end
  end

  // -------------------------------------------------------------- compare
  always @(negedge clk) begin
    if (!resetn) begin
      held8 <= '0;
      check("rst_done8", done8, 0);
      check("rst_busy8", busy8, 0);
      check("rst_result8", result8, 0);
    end else begin
      check("done8", done8, act8 && k8 == LAT8);
      check("busy8", busy8, act8 && k8 < LAT8);
      if (act8 && k8 == LAT8) begin
`ifdef MONT_FINAL_SUBTRACT_EN
        check("result8", result8, exp8);
`else
        check("result8_mod", {504'b0, result8} % em8, exp8);
        check("result8_bound", {504'b0, result8} < (em8 << 1), 1);
`endif
        held8 <= result8;
      end else if (!act8) begin
        check("hold8", result8, held8);
      end
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      held5 <= '0;
      check("rst_done512", done5, 0);
      check("rst_busy512", busy5, 0);
      check("rst_result512", result5, 0);
    end else begin
      check("done512", done5, act5 && k5 == LAT512);
      check("busy512", busy5, act5 && k5 < LAT512);
      if (act5 && k5 == LAT512) begin
`ifdef MONT_FINAL_SUBTRACT_EN
        check("result512", result5, exp5);
`else
        check("result512_mod", result5 % em5, exp5);
        check("result512_bound", result5 < (em5 << 1), 1);
`endif
        held5 <= result5;
      end else if (!act5) begin
        check("hold512", result5, held5);
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    @(negedge clk);
    a8 = a; b8 = b; m8 = m; start8 = 1'b1;
  endtask

  // Consumes the start edge, then counts edges until done is seen. Without
  // hold, start drops and the operands are scrambled to prove capture.
  // pulse_at >= 0 raises start for one cycle at that cycle count.
  task automatic wait8(input bit hold, input int pulse_at, output int lat);
    bit found;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    end
    lat = 0;
    found = 1'b0;
    for (int c = 0; c < 4 * LAT8 && !found; c++) begin
      if (done8) found = 1'b1;
      else begin
        @(posedge clk);
        lat++;
        @(negedge clk);
        if (pulse_at >= 0) start8 = (lat == pulse_at);
      end
    end
    check("done8_seen", found, 1);
  endtask

  task automatic run512(input logic [511:0] a, input logic [511:0] b,
                        input logic [511:0] m, output int lat);
    bit found;
    @(negedge clk);
    a5 = a; b5 = b; m5 = m; start5 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start5 = 1'b0; a5 = '1; b5 = '1;
    lat = 0;
    found = 1'b0;
    for (int c = 0; c < 2 * LAT512 && !found; c++) begin
      if (done5) found = 1'b1;
      else begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    check("done512_seen", found, 1);
  endtask

  task automatic lit8(input string name, input logic [7:0] want);
`ifdef MONT_FINAL_SUBTRACT_EN
    check(name, result8, want);
`else
    check(name, result8 % 8'd13, want);
`endif
  endtask

  initial begin
    int           lat;
    logic [7:0]   ra, rb, rm;
    logic [511:0] xa, xb, xm;

    // Pin the model to hand-computed values (2^-8 mod 13 = 3).
    check("pin_5x7", mont_ref(512'd5, 512'd7, 512'd13, 8), 1);
    check("pin_12x12", mont_ref(512'd12, 512'd12, 512'd13, 8), 3);
    check("pin_0x9", mont_ref(512'd0, 512'd9, 512'd13, 8), 0);

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("reset_result8", result8, 0);
    check("reset_busy512", busy5, 0);

    launch8(8'd5, 8'd7, 8'd13);
    wait8(1'b0, -1, lat);
    check("lat_5x7", lat, LAT8);
    lit8("lit_5x7", 8'd1);

    launch8(8'd12, 8'd12, 8'd13);
    wait8(1'b0, -1, lat);
    check("lat_12x12", lat, LAT8);
    lit8("lit_12x12", 8'd3);

    launch8(8'd0, 8'd9, 8'd13);
    wait8(1'b0, -1, lat);
    check("lat_0x9", lat, LAT8);
    lit8("lit_0x9", 8'd0);

    // start pulse in mid-LOOP with junk operands must be ignored.
    launch8(8'd5, 8'd7, 8'd13);
    wait8(1'b0, 3, lat);
    check("lat_midloop", lat, LAT8);
    lit8("lit_midloop", 8'd1);

    // start held through DONE: second request accepted on the done edge.
    launch8(8'd12, 8'd12, 8'd13);
    wait8(1'b1, -1, lat);
    check("lat_b2b_first", lat, LAT8);
    lit8("lit_b2b_first", 8'd3);
    a8 = 8'd5; b8 = 8'd7;
    wait8(1'b0, -1, lat);
    check("lat_b2b_second", lat, LAT8);
    lit8("lit_b2b_second", 8'd1);

    for (int v = 0; v < 8; v++) begin
`ifdef MONT_FINAL_SUBTRACT_EN
      rm = 8'(129 + 2 * $urandom_range(0, 63));
      ra = 8'($urandom_range(0, int'(rm) - 1));
      rb = 8'($urandom_range(0, int'(rm) - 1));
`else
      rm = 8'(33 + 2 * $urandom_range(0, 15));
      ra = 8'($urandom_range(0, 2 * int'(rm) - 1));
      rb = 8'($urandom_range(0, 2 * int'(rm) - 1));
`endif
      launch8(ra, rb, rm);
      wait8(1'b0, -1, lat);
      check("lat_rand8", lat, LAT8);
    end

    for (int v = 0; v < 30; v++) begin
`ifdef MONT_FINAL_SUBTRACT_EN
      xm = rand512() | {1'b1, 510'b0, 1'b1};
      xa = rand512() % xm;
      xb = rand512() % xm;
`else
      xm = (rand512() >> 2) | (512'b1 << 509) | 512'b1;
      xa = rand512() % (xm << 1);
      xb = rand512() % (xm << 1);
`endif
      run512(xa, xb, xm, lat);
      check("lat_rand512", lat, LAT512);
    end

    // Reset at cycle 100 of an N=512 run: outputs clear at once, no done.
    @(negedge clk);
    a5 = xa; b5 = xb; m5 = xm; start5 = 1'b1;
    @(posedge clk);
    start5 = 1'b0;
    repeat (100) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_done512", done5, 0);
    check("async_busy512", busy5, 0);
    check("async_result512", result5, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (LAT512 + 4) @(negedge clk);

    run512(xa, xb, xm, lat);
    check("lat_after_reset", lat, LAT512);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
